// File: rtl/tx_key_seq_if.sv
// Bus bundle for the transmit keying sequencer: key/fault inputs, the
// frequency-word handshake and the NCO / RF-chain control outputs.
interface tx_key_seq_if;
  logic        pttReq;
  logic        fault;
  logic [31:0] freqWord;
  logic        freqValid;
  logic        freqReady;
  logic [15:0] phaseIn;
  logic        ncoEnable;
  logic [31:0] ncoFreq;
  logic [15:0] ncoPhase;
  logic        trRelay;
  logic        paBias;
  logic        txActive;
  logic        faultLatched;

  modport master (
    output pttReq, fault, freqWord, freqValid, phaseIn,
    input  freqReady, ncoEnable, ncoFreq, ncoPhase, trRelay, paBias,
           txActive, faultLatched
  );

  modport slave (
    input  pttReq, fault, freqWord, freqValid, phaseIn,
    output freqReady, ncoEnable, ncoFreq, ncoPhase, trRelay, paBias,
           txActive, faultLatched
  );
endinterface

// File: rtl/tx_key_seq.sv
// Transmit keying sequencer: steps T/R relay, PA bias and NCO in a safe order
// with settle delays, and defers frequency-word changes until the PA is unbiased.
module tx_key_seq #(
  parameter int unsigned RELAY_DLY = 500000,
  parameter int unsigned BIAS_DLY  = 10000
) (
  input logic         clk,
  input logic         rstN,
  tx_key_seq_if.slave bus
);

  localparam logic [23:0] RELAY_LOAD = 24'(RELAY_DLY - 1);
  localparam logic [23:0] BIAS_LOAD  = 24'(BIAS_DLY - 1);

  typedef enum logic [2:0] {
    IDLE, RELAY_ON, BIAS_ON, TX, BIAS_OFF, RELAY_OFF, FAULT
  } state_t;

  state_t      state, stateNext;
  logic [23:0] cnt, cntNext;

  logic        relayD, biasD, txD;
  logic        trRelayQ, paBiasQ, ncoEnableQ, txActiveQ, faultLatchedQ;
  logic [15:0] ncoPhaseQ;
  logic [31:0] ncoFreqQ, shadow;
  logic        freqReadyQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // A dropped key outranks counter expiry in the forward states.
  always_comb begin
    stateNext = state;
    cntNext   = (cnt != '0) ? cnt - 24'd1 : '0;
    if (bus.fault) begin
      stateNext = FAULT;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: if (bus.pttReq) begin
          stateNext = RELAY_ON;
          cntNext   = RELAY_LOAD;
        end
        RELAY_ON: if (!bus.pttReq) begin
          stateNext = RELAY_OFF;
          cntNext   = RELAY_LOAD;
        end else if (cnt == '0) begin
          stateNext = BIAS_ON;
          cntNext   = BIAS_LOAD;
        end
        BIAS_ON: if (!bus.pttReq) begin
          stateNext = BIAS_OFF;
          cntNext   = BIAS_LOAD;
        end else if (cnt == '0) begin
          stateNext = TX;
          cntNext   = '0;
        end
        TX: if (!bus.pttReq) begin
          stateNext = BIAS_OFF;
          cntNext   = BIAS_LOAD;
        end
        BIAS_OFF: if (cnt == '0) begin
          stateNext = RELAY_OFF;
          cntNext   = RELAY_LOAD;
        end
        RELAY_OFF: if (cnt == '0) begin
          stateNext = IDLE;
        end
        FAULT: if (!bus.pttReq) begin
          stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    relayD = 1'b0;
    biasD  = 1'b0;
    txD    = 1'b0;
    case (state)
      RELAY_ON, RELAY_OFF: relayD = 1'b1;
      BIAS_ON, BIAS_OFF: begin
        relayD = 1'b1;
        biasD  = 1'b1;
      end
      TX: begin
        relayD = 1'b1;
        biasD  = 1'b1;
        txD    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      trRelayQ      <= 1'b0;
      paBiasQ       <= 1'b0;
      ncoEnableQ    <= 1'b0;
      txActiveQ     <= 1'b0;
      faultLatchedQ <= 1'b0;
      ncoPhaseQ     <= '0;
    end else begin
      trRelayQ      <= relayD;
      paBiasQ       <= biasD;
      ncoEnableQ    <= txD;
      txActiveQ     <= txD;
      faultLatchedQ <= (state == FAULT);
      ncoPhaseQ     <= txD ? bus.phaseIn : '0;
    end
  end

  // freqReadyQ doubles as the shadow-empty flag; commit is keyed off the
  // registered bias output so the word only changes once the PA is off.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      freqReadyQ <= 1'b1;
      shadow     <= '0;
      ncoFreqQ   <= '0;
    end else if (!freqReadyQ && !paBiasQ) begin
      ncoFreqQ   <= shadow;
      freqReadyQ <= 1'b1;
    end else if (freqReadyQ && bus.freqValid) begin
      shadow     <= bus.freqWord;
      freqReadyQ <= 1'b0;
    end
  end

  assign bus.trRelay      = trRelayQ;
  assign bus.paBias       = paBiasQ;
  assign bus.ncoEnable    = ncoEnableQ;
  assign bus.txActive     = txActiveQ;
  assign bus.faultLatched = faultLatchedQ;
  assign bus.ncoPhase     = ncoPhaseQ;
  assign bus.ncoFreq      = ncoFreqQ;
  assign bus.freqReady    = freqReadyQ;

endmodule
